// File: rtl/operand_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// opseq_pkg
// Shared types and constants for the operand_sequencer block:
//   - state_t   : sequencer states IDLE, LOAD_A, LOAD_B, SHOW
//   - SEL_*     : mode codes driven on the select bus
//   - LED_*     : one-hot status codes for the board LEDs
//   - led_code  : state -> one-hot LED code
//   - sel_code  : sw_mode request -> select code
// ---------------------------------------------------------------------------
package opseq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam logic [3:0] SEL_UNSIGNED = 4'b0011;
  localparam logic [3:0] SEL_TWOS     = 4'b1100;

  localparam logic [3:0] LED_IDLE   = 4'b0001;
  localparam logic [3:0] LED_LOAD_A = 4'b0010;
  localparam logic [3:0] LED_LOAD_B = 4'b0100;
  localparam logic [3:0] LED_SHOW   = 4'b1000;

  function automatic logic [3:0] led_code(input state_t s);
    case (s)
      IDLE:    led_code = LED_IDLE;
      LOAD_A:  led_code = LED_LOAD_A;
      LOAD_B:  led_code = LED_LOAD_B;
      default: led_code = LED_SHOW;
    endcase
  endfunction

  // Only the "both mode switches up" request selects two's complement.
  function automatic logic [3:0] sel_code(input logic [1:0] mode);
    sel_code = (mode == 2'b11) ? SEL_TWOS : SEL_UNSIGNED;
  endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// operand_sequencer_if
// Bundles the switch inputs and the display-datapath outputs of the
// operand sequencer.
//   sw_operand [3:0] : SW[3:0], operand value to capture
//   sw_mode    [1:0] : SW[9:8], display mode request
//   input1     [3:0] : operand A to the display datapath
//   input2     [3:0] : operand B to the display datapath
//   select     [3:0] : mode code (0011 unsigned, 1100 two's complement)
//   state_led  [3:0] : one-hot sequencer state
//   disp_en          : high only while both operands are shown
// Modports: master = sequencer side, slave = board/datapath side.
// ---------------------------------------------------------------------------
interface operand_sequencer_if;
  logic [3:0] sw_operand;
  logic [1:0] sw_mode;
  logic [3:0] input1;
  logic [3:0] input2;
  logic [3:0] select;
  logic [3:0] state_led;
  logic       disp_en;

  modport master (
    input  sw_operand, sw_mode,
    output input1, input2, select, state_led, disp_en
  );

  modport slave (
    output sw_operand, sw_mode,
    input  input1, input2, select, state_led, disp_en
  );
endinterface

// File: rtl/operand_sequencer_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronizes and debounces an active-low pushbutton and emits a
// single-cycle registered pulse on each accepted press (stable 1 -> 0).
// Releases are debounced too but never pulse.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   i_key_n   : raw active-low key, asynchronous and bouncy
//   o_step    : one-cycle pulse per accepted press
// Parameter DEB_CYCLES: cycles the synced level must differ from the stable
// level before it is accepted.
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_step
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_step;
  logic [DEB_W-1:0] r_cnt;

  // NOTE: async reset lives in the sensitivity list; every flop gets a value
  // so a reset in the middle of a count leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Released key reads high; starting at 1 keeps reset exit from
      // looking like a press.
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_step     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // NOTE: non-blocking everywhere here, so every right-hand side is the
      // pre-edge value and the order of these lines does not matter.
      r_sync1    <= i_key_n;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_step     <= r_stable_d & ~r_stable;

      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/operand_sequencer.sv
// ---------------------------------------------------------------------------
// operand_sequencer
// Step-button driven controller for the two-operand display datapath:
// IDLE -> LOAD_A -> LOAD_B -> SHOW -> LOAD_A ... advancing on each debounced
// press. In a load state the matching operand tracks the switches and freezes
// on the value present in the step cycle.
//   MAX10_CLK1_50 : 50 MHz clock, all flops on its rising edge
//   rst_n         : asynchronous active-low reset
//   key_step_n    : raw KEY[1], active-low, bouncy
//   bus (master)  : switches in; input1/input2/select/state_led/disp_en out
// Parameters: DEB_CYCLES (debounce length), DWELL_CYCLES (auto-cycle dwell).
// Build option: define OPSEQ_AUTO_CYCLE_EN to make select alternate between
// unsigned and two's complement every DWELL_CYCLES while in SHOW, ignoring
// sw_mode. Without it select follows sw_mode in SHOW.
// ---------------------------------------------------------------------------
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int DEB_CYCLES   = 500000,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  rst_n,
  input  logic                  key_step_n,
  operand_sequencer_if.master   bus
);

  if (DEB_CYCLES < 1 || DWELL_CYCLES < 1) begin : g_bad_param
    $error("operand_sequencer: DEB_CYCLES and DWELL_CYCLES must be >= 1");
  end

  logic       w_step;
  state_t     r_state;
  logic [3:0] r_input1;
  logic [3:0] r_input2;
  logic [3:0] r_select;
  logic [3:0] r_state_led;
  logic       r_disp_en;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .clk     (MAX10_CLK1_50),
    .rst_n   (rst_n),
    .i_key_n (key_step_n),
    .o_step  (w_step)
  );

`ifdef OPSEQ_AUTO_CYCLE_EN
  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  logic [DWELL_W-1:0] r_dwell;
`endif

  // LED and disp_en are loaded with the decode of the state being entered,
  // so they switch on the same edge as r_state.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_input1    <= '0;
      r_input2    <= '0;
      r_select    <= SEL_UNSIGNED;
      r_state_led <= LED_IDLE;
      r_disp_en   <= 1'b0;
`ifdef OPSEQ_AUTO_CYCLE_EN
      r_dwell     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_step) begin
            r_state     <= LOAD_A;
            r_state_led <= led_code(LOAD_A);
          end
        end

        LOAD_A: begin
          r_input1 <= bus.sw_operand;
          if (w_step) begin
            r_state     <= LOAD_B;
            r_state_led <= led_code(LOAD_B);
          end
        end

        LOAD_B: begin
          r_input2 <= bus.sw_operand;
          if (w_step) begin
            r_state     <= SHOW;
            r_state_led <= led_code(SHOW);
            r_disp_en   <= 1'b1;
`ifdef OPSEQ_AUTO_CYCLE_EN
            r_select    <= SEL_UNSIGNED;
            r_dwell     <= '0;
`else
            r_select    <= sel_code(bus.sw_mode);
`endif
          end
        end

        default: begin  // SHOW
          if (w_step) begin
            r_state     <= LOAD_A;
            r_state_led <= led_code(LOAD_A);
            r_disp_en   <= 1'b0;
            r_select    <= SEL_UNSIGNED;
`ifdef OPSEQ_AUTO_CYCLE_EN
            r_dwell     <= '0;
`endif
          end else begin
`ifdef OPSEQ_AUTO_CYCLE_EN
            if (r_dwell == DWELL_W'(DWELL_CYCLES - 1)) begin
              r_dwell  <= '0;
              r_select <= (r_select == SEL_TWOS) ? SEL_UNSIGNED : SEL_TWOS;
            end else begin
              r_dwell  <= r_dwell + 1'b1;
            end
`else
            r_select <= sel_code(bus.sw_mode);
`endif
          end
        end
      endcase
    end
  end

  assign bus.input1    = r_input1;
  assign bus.input2    = r_input2;
  assign bus.select    = r_select;
  assign bus.state_led = r_state_led;
  assign bus.disp_en   = r_disp_en;

endmodule

// File: tb/tb_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_operand_sequencer
// Directed bench for operand_sequencer with DEB_CYCLES=4, DWELL_CYCLES=8.
// A vector table walks the load/show sequence; hand-written sequences cover
// short presses, bounce, press latency, mid-debounce reset and (when
// OPSEQ_AUTO_CYCLE_EN is defined) the auto-cycling select.
// ---------------------------------------------------------------------------
module tb_operand_sequencer;
  import opseq_pkg::*;

  localparam int DEB   = 4;
  localparam int DWELL = 8;
  // Press latency: 2 sync + DEB + 1 to step, + 1 to the state change.
  localparam int PRESS_LAT = 2 + DEB + 1 + 1;

`ifdef OPSEQ_AUTO_CYCLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic key_step_n;

  operand_sequencer_if bus ();

  operand_sequencer #(
    .DEB_CYCLES   (DEB),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .rst_n         (rst_n),
    .key_step_n    (key_step_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int led_changes;

  typedef struct {
    logic       press;
    logic [3:0] op;
    logic [1:0] mode;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [3:0] sel;
    logic [3:0] led;
    logic       disp;
    logic       sel_dc;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold the key low long enough for one accepted press, then release and
  // let the release settle.
  task automatic press();
    @(negedge clk);
    key_step_n = 1'b0;
    repeat (12) @(negedge clk);
    key_step_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Drives the key low right after a falling edge and counts rising edges
  // until state_led moves; returns -1 if it never does. Key is left low.
  task automatic measure_press(output int lat);
    logic [3:0] old;
    @(negedge clk);
    old = bus.state_led;
    key_step_n = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.state_led !== old) begin
        lat = k;
        break;
      end
    end
  endtask

  // Advance n falling edges, counting state_led changes.
  task automatic tick_count(input int n);
    logic [3:0] prev;
    for (int k = 0; k < n; k++) begin
      prev = bus.state_led;
      @(negedge clk);
      if (bus.state_led !== prev) led_changes++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in1"},  bus.input1,    4'h0);
    check({tag, "_in2"},  bus.input2,    4'h0);
    check({tag, "_sel"},  bus.select,    SEL_UNSIGNED);
    check({tag, "_led"},  bus.state_led, LED_IDLE);
    check({tag, "_disp"}, bus.disp_en,   1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;

    //            press op    mode   in1   in2   sel           led         disp sel_dc
    vecs[0] = '{1'b0, 4'h0, 2'b00, 4'h0, 4'h0, SEL_UNSIGNED, LED_IDLE,   1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'h3, 2'b00, 4'h3, 4'h0, SEL_UNSIGNED, LED_LOAD_A, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'hA, 2'b00, 4'hA, 4'h0, SEL_UNSIGNED, LED_LOAD_A, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'hA, 2'b00, 4'hA, 4'hA, SEL_UNSIGNED, LED_LOAD_B, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'h5, 2'b00, 4'hA, 4'h5, SEL_UNSIGNED, LED_SHOW,   1'b1, AUTO};
    vecs[5] = '{1'b0, 4'h5, 2'b11, 4'hA, 4'h5, SEL_TWOS,     LED_SHOW,   1'b1, AUTO};
    vecs[6] = '{1'b0, 4'h5, 2'b10, 4'hA, 4'h5, SEL_UNSIGNED, LED_SHOW,   1'b1, AUTO};
    vecs[7] = '{1'b1, 4'h7, 2'b11, 4'h7, 4'h5, SEL_UNSIGNED, LED_LOAD_A, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 4'h9, 2'b11, 4'h9, 4'h9, SEL_UNSIGNED, LED_LOAD_B, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 4'h2, 2'b11, 4'h9, 4'h2, SEL_TWOS,     LED_SHOW,   1'b1, AUTO};

    rst_n          = 1'b0;
    key_step_n     = 1'b1;
    bus.sw_operand = 4'h0;
    bus.sw_mode    = 2'b00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Key low for only 3 cycles: shorter than the debounce window.
    @(negedge clk);
    key_step_n = 1'b0;
    repeat (3) @(negedge clk);
    key_step_n = 1'b1;
    repeat (10) @(negedge clk);
    check("short_press_led", bus.state_led, LED_IDLE);

    for (int i = 0; i < 10; i++) begin
      bus.sw_operand = vecs[i].op;
      bus.sw_mode    = vecs[i].mode;
      if (vecs[i].press) press();
      else repeat (2) @(negedge clk);
      check($sformatf("v%0d_in1", i),  bus.input1,    vecs[i].in1);
      check($sformatf("v%0d_in2", i),  bus.input2,    vecs[i].in2);
      check($sformatf("v%0d_led", i),  bus.state_led, vecs[i].led);
      check($sformatf("v%0d_disp", i), bus.disp_en,   vecs[i].disp);
      if (!vecs[i].sel_dc)
        check($sformatf("v%0d_sel", i), bus.select, vecs[i].sel);
    end

`ifndef OPSEQ_AUTO_CYCLE_EN
    // sw_mode reaches select one edge later, not before.
    @(negedge clk);
    bus.sw_mode = 2'b00;
    #1;
    check("mode_lat_before", bus.select, SEL_TWOS);
    @(negedge clk);
    check("mode_lat_after", bus.select, SEL_UNSIGNED);
    bus.sw_mode = 2'b11;
    @(negedge clk);
    check("mode_lat_back", bus.select, SEL_TWOS);
`endif

    // Bouncy press from SHOW: must advance exactly once, to LOAD_A.
    led_changes = 0;
    for (int i = 0; i < 5; i++) begin
      key_step_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick_count(2);
    end
    key_step_n = 1'b0;
    tick_count(20);
    key_step_n = 1'b1;
    tick_count(10);
    check("bounce_changes", led_changes, 1);
    check("bounce_led", bus.state_led, LED_LOAD_A);

    // Back to SHOW, then reset in the middle of a debounce count.
    bus.sw_operand = 4'h1;
    press();
    bus.sw_operand = 4'h6;
    press();
    check("pre_rst_led", bus.state_led, LED_SHOW);
    check("pre_rst_in2", bus.input2, 4'h6);
    @(negedge clk);
    key_step_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    key_step_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fresh press after reset: full latency, lands in LOAD_A.
    measure_press(lat);
    key_step_n = 1'b1;
    check("post_rst_latency", lat, PRESS_LAT);
    check("post_rst_led", bus.state_led, LED_LOAD_A);
    check("post_rst_in2", bus.input2, 4'h0);
    repeat (10) @(negedge clk);

`ifdef OPSEQ_AUTO_CYCLE_EN
    press();
    check("auto_pre_led", bus.state_led, LED_LOAD_B);
    bus.sw_mode = 2'b11;  // must be ignored in SHOW
    measure_press(lat);
    key_step_n = 1'b1;
    check("auto_entry_latency", lat, PRESS_LAT);
    for (int j = 0; j < 24; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("auto_sel_%0d", j), bus.select,
            ((j / DWELL) % 2 == 1) ? SEL_TWOS : SEL_UNSIGNED);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
